// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit saturating-counter predictor with BTB.
// IF side predicts direction and target for pc_if from state as of the last edge.
// EX side trains the tables with the resolved branch and flags mispredictions.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_if                    fetch PC to predict
//   pred_taken, pred_target  combinational prediction (target 0 when not taken)
//   upd_*                    resolved EX branch plus the prediction carried with it
//   mispredict, redirect_pc  combinational flush request and correct next PC
//   br_count, mp_count       saturating counts of branches and mispredictions
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_if,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS + 2;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0]    if_tag, upd_tag;
  logic                if_hit, upd_hit;
  logic                unused_pc_bits;

  assign if_idx  = pc_if[IDX_BITS+1:2];
  assign if_tag  = pc_if[31:TAG_LSB];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[31:TAG_LSB];
  // Instruction PCs are word aligned; the low bits carry no information.
  assign unused_pc_bits = ^{pc_if[1:0], upd_pc[1:0]};

  // Prediction: pure read of registered state, no bypass from a same-cycle update.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && cnt_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : 32'd0;
  end

  // Misprediction detection and redirect for the branch in EX.
  always_comb begin
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : 32'(upd_pc + 32'd4);
  end

  // Valid bits and direction counters; reset wins over an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (cnt_q[upd_idx] != 2'b11) cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
        end else begin
          if (cnt_q[upd_idx] != 2'b00) cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        cnt_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target storage (not reset). Any taken update either refreshes a
  // hitting entry (tag unchanged) or allocates, so both write the same fields.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (upd_valid && (br_count != {CNT_W{1'b1}})) br_count <= br_count + CNT_W'(1);
      if (mispredict && (mp_count != {CNT_W{1'b1}})) mp_count <= mp_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: expectations are queued when
// stimulus is driven and popped when the corresponding outputs are sampled.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  branch_predictor #(.IDX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  // Drive one EX update at a falling edge; it commits at the next rising edge.
  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle(input logic [31:0] pc);
    @(negedge clk);
    upd_valid = 1'b0; pc_if = pc;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rst = 1'b1; upd_valid = 1'b0; pc_if = 32'h0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0; pc_if = 32'h100;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL reset_pred_taken got=%0h want=%0h", pred_taken, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL reset_pred_target got=%0h want=%0h", pred_target, e); end
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL reset_br_count got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL reset_mp_count got=%0h want=%0h", mp_count, e); end
  endtask

  task automatic test_allocate;
    logic [31:0] e;
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h80);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(mispredict) !== e) begin bad++; $display("FAIL alloc_mispredict got=%0h want=%0h", mispredict, e); end
    e = exp_q.pop_front(); total++;
    if (redirect_pc !== e) begin bad++; $display("FAIL alloc_redirect got=%0h want=%0h", redirect_pc, e); end
    idle(32'h100);
    exp_q.push_back(32'h1); exp_q.push_back(32'h80); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL alloc_pred_taken got=%0h want=%0h", pred_taken, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL alloc_pred_target got=%0h want=%0h", pred_target, e); end
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL alloc_br_count got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL alloc_mp_count got=%0h want=%0h", mp_count, e); end
  endtask

  task automatic test_saturate_counter;
    logic [31:0] e;
    // Three correctly predicted taken updates: 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); total++;
      if (32'(mispredict) !== e) begin bad++; $display("FAIL sat_taken_mispredict[%0d] got=%0h want=%0h", i, mispredict, e); end
    end
    // First not-taken: 11 -> 10, still predicts taken.
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL sat_after_nt1 got=%0h want=%0h", pred_taken, e); end
    // Second not-taken: 10 -> 01, predicts not taken and target reads 0.
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL sat_after_nt2 got=%0h want=%0h", pred_taken, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL sat_after_nt2_target got=%0h want=%0h", pred_target, e); end
    // Not taken but predicted taken: redirect to fall-through.
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    exp_q.push_back(32'h1); exp_q.push_back(32'h104);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(mispredict) !== e) begin bad++; $display("FAIL nt_mispredict got=%0h want=%0h", mispredict, e); end
    e = exp_q.pop_front(); total++;
    if (redirect_pc !== e) begin bad++; $display("FAIL nt_redirect got=%0h want=%0h", redirect_pc, e); end
    idle(32'h100);
    exp_q.push_back(32'd7); exp_q.push_back(32'd2);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL sat_br_count got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL sat_mp_count got=%0h want=%0h", mp_count, e); end
  endtask

  task automatic test_alias;
    logic [31:0] e;
    drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    idle(32'h100);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL alias_old_pc got=%0h want=%0h", pred_taken, e); end
    pc_if = 32'h140;
    exp_q.push_back(32'h1); exp_q.push_back(32'h300);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL alias_new_pc got=%0h want=%0h", pred_taken, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL alias_new_target got=%0h want=%0h", pred_target, e); end
    // A not-taken miss at the aliasing PC must leave the entry alone.
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h140);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL alias_nt_miss_kept got=%0h want=%0h", pred_taken, e); end
  endtask

  task automatic test_wrong_target;
    logic [31:0] e;
    drive_upd(32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    pc_if = 32'h140;
    exp_q.push_back(32'h1); exp_q.push_back(32'h240); exp_q.push_back(32'h300);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(mispredict) !== e) begin bad++; $display("FAIL tgt_mispredict got=%0h want=%0h", mispredict, e); end
    e = exp_q.pop_front(); total++;
    if (redirect_pc !== e) begin bad++; $display("FAIL tgt_redirect got=%0h want=%0h", redirect_pc, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL same_cycle_old_target got=%0h want=%0h", pred_target, e); end
    idle(32'h140);
    exp_q.push_back(32'h240); exp_q.push_back(32'd10); exp_q.push_back(32'd4);
    #1;
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL tgt_new_target got=%0h want=%0h", pred_target, e); end
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL tgt_br_count got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL tgt_mp_count got=%0h want=%0h", mp_count, e); end
  endtask

  task automatic test_count_saturate;
    logic [31:0] e;
    // br_count is 10 here; 65525 back-to-back correct not-taken updates reach 0xFFFF.
    drive_upd(32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (65525) @(posedge clk);
    idle(32'h140);
    exp_q.push_back(32'hFFFF); exp_q.push_back(32'd4);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL br_reach_max got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL mp_unchanged got=%0h want=%0h", mp_count, e); end
    drive_upd(32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h140);
    exp_q.push_back(32'hFFFF);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL br_hold_max got=%0h want=%0h", br_count, e); end
  endtask

  task automatic test_reset_during_update;
    logic [31:0] e;
    drive_upd(32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
    rst = 1'b1;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(mispredict) !== e) begin bad++; $display("FAIL rst_mispredict_follows got=%0h want=%0h", mispredict, e); end
    @(negedge clk);
    rst = 1'b0; upd_valid = 1'b0; pc_if = 32'h140;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL rst_upd_pred_taken got=%0h want=%0h", pred_taken, e); end
    e = exp_q.pop_front(); total++;
    if (pred_target !== e) begin bad++; $display("FAIL rst_upd_pred_target got=%0h want=%0h", pred_target, e); end
    e = exp_q.pop_front(); total++;
    if (32'(br_count) !== e) begin bad++; $display("FAIL rst_upd_br_count got=%0h want=%0h", br_count, e); end
    e = exp_q.pop_front(); total++;
    if (32'(mp_count) !== e) begin bad++; $display("FAIL rst_upd_mp_count got=%0h want=%0h", mp_count, e); end
    // Fresh allocation after reset starts weakly taken.
    drive_upd(32'h100, 1'b1, 32'h88, 1'b0, 32'h0);
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h88);
    idle(32'h100);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(pred_taken) !== e) begin bad++; $display("FAIL realloc_weak got=%0h want=%0h", pred_taken, e); end
  endtask

  initial begin
    test_reset;
    test_allocate;
    test_saturate_counter;
    test_alias;
    test_wrong_target;
    test_count_saturate;
    test_reset_during_update;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV32I core, paired with the EX-stage branching unit. In IF it predicts taken/not-taken and the target for the fetch PC. In EX it takes the resolved branch outcome, updates its tables and flags mispredictions so the hazard unit can flush and redirect. It uses a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB).

## Interface
Parameters:
- IDX_BITS, 4, log2 of table entries (16 entries); index = pc[IDX_BITS+1:2]
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_if  input  32  current fetch PC
- pred_taken  output  1  prediction for pc_if (combinational from stored state)
- pred_target  output  32  predicted target; 0 when pred_taken=0
- upd_valid  input  1  EX holds a conditional branch (Branch control bit)
- upd_pc  input  32  PC of the EX branch
- upd_taken  input  1  resolved outcome (TakeBranch)
- upd_target  input  32  resolved branch target
- upd_pred_taken  input  1  prediction made for this branch, carried down the pipeline
- upd_pred_target  input  32  predicted target, carried down the pipeline
- mispredict  output  1  combinational; flush IF/ID and ID/EX when high
- redirect_pc  output  32  correct next PC when mispredict=1
- br_count  output  CNT_W  resolved branches since reset
- mp_count  output  CNT_W  mispredictions since reset

## Operation
Entry i stores:
- valid (1 bit)
- tag = pc[31:IDX_BITS+2]
- target (32 bits)
- cnt (2 bits): 00 strong NT, 01 weak NT, 10 weak T, 11 strong T

Predict (combinational):
- hit = valid[i] && tag[i] == pc_if tag bits
- pred_taken = hit && cnt[i][1]
- pred_target = pred_taken ? target[i] : 0

Update (clocked, only when upd_valid=1; index and tag taken from upd_pc):
- hit, upd_taken=1: cnt = min(cnt+1, 3); target = upd_target.
- hit, upd_taken=0: cnt = max(cnt-1, 0). Entry stays valid.
- miss, upd_taken=1: allocate (overwrite). valid=1, tag written, target=upd_target, cnt=10.
- miss, upd_taken=0: no table change.

Mispredict (combinational):
- mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target))
- redirect_pc = upd_taken ? upd_target : upd_pc + 4 (32-bit wrap). Value is don't-care when mispredict=0; the driven value is the same formula.

Statistics:
- br_count increments on every cycle with upd_valid=1.
- mp_count increments on every cycle with mispredict=1.
- Both saturate at all-ones and do not wrap.

## Timing
- Reset (rst=1 at an edge) clears all valid bits, sets all cnt to 01, and zeroes br_count and mp_count. Targets and tags are not reset.
- Outputs during and after reset:
  - pred_taken=0 and pred_target=0 for any PC.
  - mispredict follows its inputs (the pipeline holds upd_valid=0 during reset).
- Reset takes priority over an update in the same cycle; the update is dropped.
- Prediction latency is zero: a combinational read of state as of the last edge.
- An update becomes visible to prediction on the cycle after its edge.
- Same-cycle read/write of the same index: the prediction uses pre-update state. There is no bypass.
- mispredict and redirect_pc are valid in the same cycle as upd_*. Statistics update at the following edge.
- An aliasing PC with a different tag overwrites the entry only on a taken miss.
- upd_valid=0 causes no state change.

## Test plan
1. Reset, then pc_if=0x100 -> pred_taken=0, pred_target=0, br_count=0, mp_count=0.
2. Branch at 0x100 resolved taken to 0x80 with upd_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle pc_if=0x100 gives pred_taken=1, pred_target=0x80; br_count=1, mp_count=1.
3. Same branch resolved taken three more times -> cnt saturates at 11. Then two not-taken updates -> cnt=01, pred_taken=0. A not-taken update with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x104.
4. Taken branch at 0x140 (same index as 0x100 with IDX_BITS=4, different tag) -> entry replaced. pc_if=0x100 gives pred_taken=0; pc_if=0x140 gives pred_taken=1.
5. Correct prediction but wrong target: upd_taken=1, upd_pred_taken=1, upd_pred_target=0x200, upd_target=0x240 -> mispredict=1, redirect_pc=0x240. Also check the same-cycle read of the index being updated returns the old state.
6. Force br_count to 0xFFFF via 65535 updates plus one more -> count holds at 0xFFFF. Assert rst in the middle of an update -> tables and counters return to their reset values and the update has no effect.
